// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI definitions used by the channel slice
package axi_pkg;

    // Per-channel buffering mode of a channel slice
    typedef enum logic [1:0] {
        SLICE_BYPASS = 2'd0,
        SLICE_HALF   = 2'd1,
        SLICE_FULL   = 2'd2
    } slice_mode_e;

    // Fixed-width AXI4 fields
    localparam int unsigned AXI_LEN_WIDTH    = 8;
    localparam int unsigned AXI_SIZE_WIDTH   = 3;
    localparam int unsigned AXI_BURST_WIDTH  = 2;
    localparam int unsigned AXI_CACHE_WIDTH  = 4;
    localparam int unsigned AXI_PROT_WIDTH   = 3;
    localparam int unsigned AXI_QOS_WIDTH    = 4;
    localparam int unsigned AXI_REGION_WIDTH = 4;
    localparam int unsigned AXI_ATOP_WIDTH   = 6;
    localparam int unsigned AXI_RESP_WIDTH   = 2;

    // True when a mode value maps onto one of the slice_mode_e encodings
    function automatic bit slice_mode_legal(input int unsigned mode);
        return mode <= 32'd2;
    endfunction

endpackage

// File: rtl/axi_bus.sv
// rtl/axi_bus.sv - AXI4 bus interface with master and slave views
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 5,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [5:0]                aw_atop;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axi_chan_reg.sv
// rtl/axi_chan_reg.sv - one valid/ready channel stage: bypass, half or full spill register
module axi_chan_reg
    import axi_pkg::*;
#(
    parameter int unsigned MODE = 2,
    parameter type         T    = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    if (!slice_mode_legal(MODE)) begin : g_illegal_mode
        $error("axi_chan_reg: MODE %0d is not 0 (bypass), 1 (half) or 2 (full)", MODE);
    end

    if (MODE == int'(SLICE_BYPASS)) begin : g_bypass
        // Pure wiring: clock and reset have no load in this mode
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;

        assign valid_o = valid_i;
        assign data_o  = data_i;
        assign ready_o = ready_i;

    end else if (MODE == int'(SLICE_HALF)) begin : g_half
        logic full_d, full_q;
        T     data_d, data_q;

        // Load when empty, drain when downstream takes it; both cannot coincide
        always_comb begin
            full_d = full_q;
            data_d = data_q;
            if (valid_i && !full_q) begin
                full_d = 1'b1;
                data_d = data_i;
            end else if (full_q && ready_i) begin
                full_d = 1'b0;
            end
        end

        // Slot flag and payload register
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                full_q <= 1'b0;
                data_q <= '0;
            end else begin
                full_q <= full_d;
                data_q <= data_d;
            end
        end

        assign ready_o = !full_q;
        assign valid_o = full_q;
        assign data_o  = data_q;

    end else begin : g_full
        logic a_full_d, a_full_q;
        logic b_full_d, b_full_q;
        T     a_d, a_q;
        T     b_d, b_q;
        logic push, pop;

        // ready depends only on the spill flag, so ready_i never reaches ready_o
        assign push = valid_i && !b_full_q;
        assign pop  = a_full_q && ready_i;

        // A feeds the output; B catches the beat that arrives while A is stalled
        always_comb begin
            a_full_d = a_full_q;
            b_full_d = b_full_q;
            a_d      = a_q;
            b_d      = b_q;
            if (pop && b_full_q) begin
                a_d      = b_q;
                b_full_d = 1'b0;
            end else if (push && (!a_full_q || pop)) begin
                a_d      = data_i;
                a_full_d = 1'b1;
            end else if (push) begin
                b_d      = data_i;
                b_full_d = 1'b1;
            end else if (pop) begin
                a_full_d = 1'b0;
            end
        end

        // Slot flags and payload registers
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                a_full_q <= 1'b0;
                b_full_q <= 1'b0;
                a_q      <= '0;
                b_q      <= '0;
            end else begin
                a_full_q <= a_full_d;
                b_full_q <= b_full_d;
                a_q      <= a_d;
                b_q      <= b_d;
            end
        end

        assign ready_o = !b_full_q;
        assign valid_o = a_full_q;
        assign data_o  = a_q;
    end

endmodule

// File: rtl/axi_channel_slice.sv
// rtl/axi_channel_slice.sv - AXI4 pipeline stage with an independent register mode per channel
module axi_channel_slice
    import axi_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 5,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned AW_MODE        = 2,
    parameter int unsigned W_MODE         = 2,
    parameter int unsigned B_MODE         = 1,
    parameter int unsigned AR_MODE        = 2,
    parameter int unsigned R_MODE         = 2
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    AXI_BUS.Slave  slv,
    AXI_BUS.Master mst
);

    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]     id;
        logic [AXI_ADDR_WIDTH-1:0]   addr;
        logic [AXI_LEN_WIDTH-1:0]    len;
        logic [AXI_SIZE_WIDTH-1:0]   size;
        logic [AXI_BURST_WIDTH-1:0]  burst;
        logic                        lock;
        logic [AXI_CACHE_WIDTH-1:0]  cache;
        logic [AXI_PROT_WIDTH-1:0]   prot;
        logic [AXI_QOS_WIDTH-1:0]    qos;
        logic [AXI_REGION_WIDTH-1:0] region;
        logic [AXI_ATOP_WIDTH-1:0]   atop;
        logic [AXI_USER_WIDTH-1:0]   user;
    } aw_chan_t;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0]     strb;
        logic                      last;
        logic [AXI_USER_WIDTH-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_RESP_WIDTH-1:0] resp;
        logic [AXI_USER_WIDTH-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]     id;
        logic [AXI_ADDR_WIDTH-1:0]   addr;
        logic [AXI_LEN_WIDTH-1:0]    len;
        logic [AXI_SIZE_WIDTH-1:0]   size;
        logic [AXI_BURST_WIDTH-1:0]  burst;
        logic                        lock;
        logic [AXI_CACHE_WIDTH-1:0]  cache;
        logic [AXI_PROT_WIDTH-1:0]   prot;
        logic [AXI_QOS_WIDTH-1:0]    qos;
        logic [AXI_REGION_WIDTH-1:0] region;
        logic [AXI_USER_WIDTH-1:0]   user;
    } ar_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [AXI_RESP_WIDTH-1:0] resp;
        logic                      last;
        logic [AXI_USER_WIDTH-1:0] user;
    } r_chan_t;

    aw_chan_t aw_in, aw_out;
    w_chan_t  w_in,  w_out;
    b_chan_t  b_in,  b_out;
    ar_chan_t ar_in, ar_out;
    r_chan_t  r_in,  r_out;

    // Pack the incoming side of every channel
    assign aw_in = '{id: slv.aw_id, addr: slv.aw_addr, len: slv.aw_len, size: slv.aw_size,
                     burst: slv.aw_burst, lock: slv.aw_lock, cache: slv.aw_cache,
                     prot: slv.aw_prot, qos: slv.aw_qos, region: slv.aw_region,
                     atop: slv.aw_atop, user: slv.aw_user};
    assign w_in  = '{data: slv.w_data, strb: slv.w_strb, last: slv.w_last, user: slv.w_user};
    assign b_in  = '{id: mst.b_id, resp: mst.b_resp, user: mst.b_user};
    assign ar_in = '{id: slv.ar_id, addr: slv.ar_addr, len: slv.ar_len, size: slv.ar_size,
                     burst: slv.ar_burst, lock: slv.ar_lock, cache: slv.ar_cache,
                     prot: slv.ar_prot, qos: slv.ar_qos, region: slv.ar_region,
                     user: slv.ar_user};
    assign r_in  = '{id: mst.r_id, data: mst.r_data, resp: mst.r_resp, last: mst.r_last,
                     user: mst.r_user};

    // Unpack the outgoing side of every channel
    assign mst.aw_id     = aw_out.id;
    assign mst.aw_addr   = aw_out.addr;
    assign mst.aw_len    = aw_out.len;
    assign mst.aw_size   = aw_out.size;
    assign mst.aw_burst  = aw_out.burst;
    assign mst.aw_lock   = aw_out.lock;
    assign mst.aw_cache  = aw_out.cache;
    assign mst.aw_prot   = aw_out.prot;
    assign mst.aw_qos    = aw_out.qos;
    assign mst.aw_region = aw_out.region;
    assign mst.aw_atop   = aw_out.atop;
    assign mst.aw_user   = aw_out.user;

    assign mst.w_data    = w_out.data;
    assign mst.w_strb    = w_out.strb;
    assign mst.w_last    = w_out.last;
    assign mst.w_user    = w_out.user;

    assign slv.b_id      = b_out.id;
    assign slv.b_resp    = b_out.resp;
    assign slv.b_user    = b_out.user;

    assign mst.ar_id     = ar_out.id;
    assign mst.ar_addr   = ar_out.addr;
    assign mst.ar_len    = ar_out.len;
    assign mst.ar_size   = ar_out.size;
    assign mst.ar_burst  = ar_out.burst;
    assign mst.ar_lock   = ar_out.lock;
    assign mst.ar_cache  = ar_out.cache;
    assign mst.ar_prot   = ar_out.prot;
    assign mst.ar_qos    = ar_out.qos;
    assign mst.ar_region = ar_out.region;
    assign mst.ar_user   = ar_out.user;

    assign slv.r_id      = r_out.id;
    assign slv.r_data    = r_out.data;
    assign slv.r_resp    = r_out.resp;
    assign slv.r_last    = r_out.last;
    assign slv.r_user    = r_out.user;

    axi_chan_reg #(.MODE(AW_MODE), .T(aw_chan_t)) i_aw_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (slv.aw_valid),
        .ready_o (slv.aw_ready),
        .data_i  (aw_in),
        .valid_o (mst.aw_valid),
        .ready_i (mst.aw_ready),
        .data_o  (aw_out)
    );

    axi_chan_reg #(.MODE(W_MODE), .T(w_chan_t)) i_w_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (slv.w_valid),
        .ready_o (slv.w_ready),
        .data_i  (w_in),
        .valid_o (mst.w_valid),
        .ready_i (mst.w_ready),
        .data_o  (w_out)
    );

    axi_chan_reg #(.MODE(B_MODE), .T(b_chan_t)) i_b_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (mst.b_valid),
        .ready_o (mst.b_ready),
        .data_i  (b_in),
        .valid_o (slv.b_valid),
        .ready_i (slv.b_ready),
        .data_o  (b_out)
    );

    axi_chan_reg #(.MODE(AR_MODE), .T(ar_chan_t)) i_ar_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (slv.ar_valid),
        .ready_o (slv.ar_ready),
        .data_i  (ar_in),
        .valid_o (mst.ar_valid),
        .ready_i (mst.ar_ready),
        .data_o  (ar_out)
    );

    axi_chan_reg #(.MODE(R_MODE), .T(r_chan_t)) i_r_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (mst.r_valid),
        .ready_o (mst.r_ready),
        .data_i  (r_in),
        .valid_o (slv.r_valid),
        .ready_i (slv.r_ready),
        .data_o  (r_out)
    );

endmodule

// File: tb/tb_axi_channel_slice.sv
// tb/tb_axi_channel_slice.sv - self-checking bench for axi_channel_slice
module tb_axi_channel_slice;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(5), .AXI_USER_WIDTH(1)) slv_bus ();
    AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(5), .AXI_USER_WIDTH(1)) mst_bus ();

    axi_channel_slice #(
        .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(5), .AXI_USER_WIDTH(1),
        .AW_MODE(2), .W_MODE(2), .B_MODE(1), .AR_MODE(2), .R_MODE(0)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .slv    (slv_bus),
        .mst    (mst_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference FIFO contents for the random phase: W holds up to 2 beats, B up to 1
    logic [64:0] w_model[$];
    logic [6:0]  b_model[$];
    logic        acc;
    logic        w_push, w_pop, b_push, b_pop;
    int          bid;

    initial begin
        slv_bus.aw_id = '0; slv_bus.aw_addr = '0; slv_bus.aw_len = '0; slv_bus.aw_size = '0;
        slv_bus.aw_burst = '0; slv_bus.aw_lock = 1'b0; slv_bus.aw_cache = '0; slv_bus.aw_prot = '0;
        slv_bus.aw_qos = '0; slv_bus.aw_region = '0; slv_bus.aw_atop = '0; slv_bus.aw_user = '0;
        slv_bus.aw_valid = 1'b0;
        slv_bus.w_data = '0; slv_bus.w_strb = '0; slv_bus.w_last = 1'b0; slv_bus.w_user = '0;
        slv_bus.w_valid = 1'b0;
        slv_bus.b_ready = 1'b0;
        slv_bus.ar_id = '0; slv_bus.ar_addr = '0; slv_bus.ar_len = '0; slv_bus.ar_size = '0;
        slv_bus.ar_burst = '0; slv_bus.ar_lock = 1'b0; slv_bus.ar_cache = '0; slv_bus.ar_prot = '0;
        slv_bus.ar_qos = '0; slv_bus.ar_region = '0; slv_bus.ar_user = '0; slv_bus.ar_valid = 1'b0;
        slv_bus.r_ready = 1'b0;
        mst_bus.aw_ready = 1'b0; mst_bus.w_ready = 1'b0; mst_bus.ar_ready = 1'b0;
        mst_bus.b_id = '0; mst_bus.b_resp = '0; mst_bus.b_user = '0; mst_bus.b_valid = 1'b0;
        mst_bus.r_id = '0; mst_bus.r_data = '0; mst_bus.r_resp = '0; mst_bus.r_last = 1'b0;
        mst_bus.r_user = '0; mst_bus.r_valid = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_aw_valid", mst_bus.aw_valid, 1'b0);
        check("rst_w_valid", mst_bus.w_valid, 1'b0);
        check("rst_ar_valid", mst_bus.ar_valid, 1'b0);
        check("rst_b_valid", slv_bus.b_valid, 1'b0);
        check("rst_r_valid", slv_bus.r_valid, 1'b0);
        check("rst_aw_ready", slv_bus.aw_ready, 1'b1);
        check("rst_w_ready", slv_bus.w_ready, 1'b1);
        check("rst_ar_ready", slv_bus.ar_ready, 1'b1);
        check("rst_b_ready", mst_bus.b_ready, 1'b1);
        check("rst_r_ready", mst_bus.r_ready, 1'b0);
        check("rst_aw_addr", mst_bus.aw_addr, 64'h0);
        check("rst_w_data", mst_bus.w_data, 64'h0);
        check("rst_ar_addr", mst_bus.ar_addr, 64'h0);
        check("rst_b_id", slv_bus.b_id, 5'h0);

        // ---- AW full mode, back-to-back ----
        mst_bus.aw_ready = 1'b1;
        @(posedge clk); #1;
        slv_bus.aw_valid = 1'b1;
        slv_bus.aw_addr  = 64'h1000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) slv_bus.aw_addr = 64'h1000 + 64'(8 * (i + 1));
            else       slv_bus.aw_valid = 1'b0;
            @(negedge clk);
            check("aw_tp_valid", mst_bus.aw_valid, 1'b1);
            check("aw_tp_addr", mst_bus.aw_addr, 64'h1000 + 64'(8 * i));
            check("aw_tp_ready", slv_bus.aw_ready, 1'b1);
        end
        @(negedge clk);
        check("aw_tp_drain", mst_bus.aw_valid, 1'b0);

        // ---- W full mode backpressure ----
        mst_bus.w_ready = 1'b0;
        @(posedge clk); #1;
        slv_bus.w_valid = 1'b1; slv_bus.w_data = 64'hA; slv_bus.w_last = 1'b0;
        @(posedge clk); #1;
        slv_bus.w_data = 64'hB; slv_bus.w_last = 1'b1;
        @(posedge clk); #1;
        slv_bus.w_valid = 1'b0;
        @(negedge clk);
        check("w_bp_ready_low", slv_bus.w_ready, 1'b0);
        check("w_bp_valid", mst_bus.w_valid, 1'b1);
        check("w_bp_hold_a", mst_bus.w_data, 64'hA);
        @(negedge clk);
        check("w_bp_hold_a2", mst_bus.w_data, 64'hA);
        check("w_bp_ready_low2", slv_bus.w_ready, 1'b0);
        @(posedge clk); #1;
        mst_bus.w_ready = 1'b1;
        @(negedge clk);
        check("w_out_a", mst_bus.w_data, 64'hA);
        check("w_out_a_last", mst_bus.w_last, 1'b0);
        @(negedge clk);
        check("w_out_b_valid", mst_bus.w_valid, 1'b1);
        check("w_out_b", mst_bus.w_data, 64'hB);
        check("w_out_b_last", mst_bus.w_last, 1'b1);
        check("w_ready_back", slv_bus.w_ready, 1'b1);
        @(negedge clk);
        check("w_drain", mst_bus.w_valid, 1'b0);

        // ---- B half mode: one beat every two cycles ----
        @(posedge clk); #1;
        slv_bus.b_ready = 1'b1;
        mst_bus.b_valid = 1'b1; bid = 3; mst_bus.b_id = 5'(bid); mst_bus.b_resp = 2'b10;
        @(negedge clk);
        acc = mst_bus.b_valid && mst_bus.b_ready;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (acc) begin
                if (bid == 5) mst_bus.b_valid = 1'b0;
                else begin bid++; mst_bus.b_id = 5'(bid); end
            end
            @(negedge clk);
            check("b_half_valid", slv_bus.b_valid, 1'((k % 2) == 1));
            if ((k % 2) == 1) begin
                check("b_half_id", slv_bus.b_id, 5'(3 + (k - 1) / 2));
                check("b_half_resp", slv_bus.b_resp, 2'b10);
            end
            acc = mst_bus.b_valid && mst_bus.b_ready;
        end
        slv_bus.b_ready = 1'b0;

        // ---- R bypass: combinational in both directions ----
        mst_bus.r_data = 64'hDEADBEEF; mst_bus.r_last = 1'b1; mst_bus.r_valid = 1'b1;
        slv_bus.r_ready = 1'b0;
        #1;
        check("r_byp_valid", slv_bus.r_valid, 1'b1);
        check("r_byp_data", slv_bus.r_data, 64'hDEADBEEF);
        check("r_byp_last", slv_bus.r_last, 1'b1);
        check("r_byp_ready0", mst_bus.r_ready, 1'b0);
        slv_bus.r_ready = 1'b1;
        #1;
        check("r_byp_ready1", mst_bus.r_ready, 1'b1);
        mst_bus.r_valid = 1'b0; mst_bus.r_last = 1'b0; slv_bus.r_ready = 1'b0;

        // ---- AR reset mid-burst ----
        mst_bus.ar_ready = 1'b0;
        @(posedge clk); #1;
        slv_bus.ar_valid = 1'b1; slv_bus.ar_addr = 64'h2000;
        @(posedge clk); #1;
        slv_bus.ar_addr = 64'h2008;
        @(posedge clk); #1;
        slv_bus.ar_valid = 1'b0;
        @(negedge clk);
        check("ar_held_valid", mst_bus.ar_valid, 1'b1);
        check("ar_held_addr", mst_bus.ar_addr, 64'h2000);
        check("ar_full_ready", slv_bus.ar_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_async_valid", mst_bus.ar_valid, 1'b0);
        check("ar_async_ready", slv_bus.ar_ready, 1'b1);
        check("ar_async_addr", mst_bus.ar_addr, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mst_bus.ar_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ar_no_stale", mst_bus.ar_valid, 1'b0);
        end

        // ---- random traffic on W (full) and B (half) against FIFO model ----
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            slv_bus.w_valid = 1'($urandom_range(0, 1));
            slv_bus.w_data  = {$urandom, $urandom};
            slv_bus.w_last  = 1'($urandom_range(0, 1));
            mst_bus.w_ready = ($urandom_range(0, 3) != 0);
            mst_bus.b_valid = 1'($urandom_range(0, 1));
            mst_bus.b_id    = 5'($urandom_range(0, 31));
            mst_bus.b_resp  = 2'($urandom_range(0, 3));
            slv_bus.b_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            check("rnd_w_valid", mst_bus.w_valid, 1'(w_model.size() > 0));
            check("rnd_w_ready", slv_bus.w_ready, 1'(w_model.size() < 2));
            if (w_model.size() > 0) check("rnd_w_beat", {mst_bus.w_last, mst_bus.w_data}, w_model[0]);
            check("rnd_b_valid", slv_bus.b_valid, 1'(b_model.size() > 0));
            check("rnd_b_ready", mst_bus.b_ready, 1'(b_model.size() < 1));
            if (b_model.size() > 0) check("rnd_b_beat", {slv_bus.b_id, slv_bus.b_resp}, b_model[0]);
            w_pop  = (w_model.size() > 0) && mst_bus.w_ready;
            w_push = slv_bus.w_valid && (w_model.size() < 2);
            b_pop  = (b_model.size() > 0) && slv_bus.b_ready;
            b_push = mst_bus.b_valid && (b_model.size() < 1);
            if (w_pop)  void'(w_model.pop_front());
            if (w_push) w_model.push_back({slv_bus.w_last, slv_bus.w_data});
            if (b_pop)  void'(b_model.pop_front());
            if (b_push) b_model.push_back({mst_bus.b_id, mst_bus.b_resp});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
